ex_div: RTL and testbench

// Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU, owned by the EX stage.
// EX raises start_i when the aluop latched by id_ex is a divide and holds EX

---
 rtl/ex_div.sv | 184 ++++++++++++++++++
 tb/tb_ex_div.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_div.sv
// ex_div -- iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//
// EX raises start_i for a divide and stalls until ready_o pulses. One
// quotient bit is produced per clock, so a normal operation returns its
// result WIDTH+1 cycles after start_i is sampled. A zero divisor and the
// signed overflow case (most-negative / -1) bypass the iteration and
// complete on the very next cycle.
//
// Ports
//   clk          in   1        clock, rising edge
//   rst          in   1        asynchronous reset, active low
//   signed_div_i in   1        1 = DIV/REM (two's complement), 0 = DIVU/REMU
//   opdata1_i    in   WIDTH    dividend
//   opdata2_i    in   WIDTH    divisor
//   start_i      in   1        request, sampled only while idle
//   annul_i      in   1        abort the current operation (pipeline flush)
//   result_o     out  2*WIDTH  {remainder, quotient}, held until next completion
//   ready_o      out  1        one-cycle pulse: result_o is valid
//   busy_o       out  1        operation in progress or completing
module ex_div #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_n;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_r;
  logic             q_neg_r;
  logic             r_neg_r;

  logic             start_ok_s;
  logic             op1_neg_s;
  logic             op2_neg_s;
  logic             div_zero_s;
  logic             ovf_s;
  logic [WIDTH-1:0] abs1_s;
  logic [WIDTH-1:0] abs2_s;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH+1:0] trial_s;
  logic             take_s;
  logic [WIDTH-1:0] rem_step_s;
  logic [WIDTH-1:0] quo_step_s;
  logic [WIDTH-1:0] rem_fin_s;
  logic [WIDTH-1:0] quo_fin_s;
  logic             last_s;

  // Operand decode and one restoring iteration of the datapath.
  always_comb begin
    start_ok_s = start_i & ~annul_i;
    op1_neg_s  = signed_div_i & opdata1_i[WIDTH-1];
    op2_neg_s  = signed_div_i & opdata2_i[WIDTH-1];
    div_zero_s = (opdata2_i == ZERO_W);
    ovf_s      = signed_div_i & (opdata1_i == MOST_NEG) & (opdata2_i == ONES_W);
    abs1_s     = op1_neg_s ? (ZERO_W - opdata1_i) : opdata1_i;
    abs2_s     = op2_neg_s ? (ZERO_W - opdata2_i) : opdata2_i;
    // The shifted partial remainder can reach 2*divisor-1, which needs
    // WIDTH+1 bits for a full-range unsigned divisor; one more bit holds
    // the borrow of the trial subtraction.
    shifted_s  = {rem_r, quo_r[WIDTH-1]};
    trial_s    = {1'b0, shifted_s} - {2'b00, dvs_r};
    take_s     = ~trial_s[WIDTH+1];
    // Whichever branch is taken, the new remainder is below the divisor,
    // so the low WIDTH bits are exact.
    rem_step_s = take_s ? trial_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
    quo_step_s = {quo_r[WIDTH-2:0], take_s};
    rem_fin_s  = r_neg_r ? (ZERO_W - rem_step_s) : rem_step_s;
    quo_fin_s  = q_neg_r ? (ZERO_W - quo_step_s) : quo_step_s;
    last_s     = (cnt_r == CNT_LAST);
  end

  // Next-state logic; annul_i overrides a completing iteration.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          if (div_zero_s || ovf_s) begin
            state_n = DONE;
          end else begin
            state_n = BUSY;
          end
        end else begin
          state_n = IDLE;
        end
      end
      BUSY: begin
        if (annul_i) begin
          state_n = IDLE;
        end else if (last_s) begin
          state_n = DONE;
        end else begin
          state_n = BUSY;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Datapath registers and registered status/result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r    <= {CW{1'b0}};
      rem_r    <= ZERO_W;
      quo_r    <= ZERO_W;
      dvs_r    <= ZERO_W;
      q_neg_r  <= 1'b0;
      r_neg_r  <= 1'b0;
      result_o <= {(2*WIDTH){1'b0}};
      ready_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      ready_o <= (state_n == DONE);
      busy_o  <= (state_n != IDLE);
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            if (div_zero_s) begin
              result_o <= {opdata1_i, ONES_W};
            end else if (ovf_s) begin
              result_o <= {ZERO_W, opdata1_i};
            end else begin
              cnt_r   <= {CW{1'b0}};
              rem_r   <= ZERO_W;
              quo_r   <= abs1_s;
              dvs_r   <= abs2_s;
              q_neg_r <= op1_neg_s ^ op2_neg_s;
              r_neg_r <= op1_neg_s;
            end
          end
        end
        BUSY: begin
          if (annul_i) begin
            cnt_r <= {CW{1'b0}};
          end else begin
            rem_r <= rem_step_s;
            quo_r <= quo_step_s;
            cnt_r <= cnt_r + CNT_ONE;
            if (last_s) begin
              result_o <= {rem_fin_s, quo_fin_s};
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed corner cases plus random
// operations, checked by a queue-based scoreboard against an arithmetic
// reference model. Expected results carry the cycle in which ready_o must
// pulse, so latency and pulse width are checked together with the data.
module tb_ex_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [63:0] last_res;

  ex_div #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle number; cycle k is the interval following the k-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: RISC-V divide semantics via 64-bit integer arithmetic.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int latency(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Drive one request for one cycle; optionally record the expectation.
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    if (push) begin
      e.res = model(sgn, a, b);
      e.cyc = cyc + latency(sgn, a, b);
      sb_q.push_back(e);
      last_res = e.res;
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  // Wait until every expected result has arrived and the divider is idle.
  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy_o) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (n >= 200) begin
      fails++;
      $display("FAIL %s_timeout: %0d results outstanding, busy_o=%0b", nm, sb_q.size(), busy_o);
      sb_q.delete();
    end
  endtask

  // Monitor: every ready_o pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && ready_o) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ready: result %h in cycle %0d, none expected", result_o, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("result", result_o, mon_e.res);
        check("ready_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("busy_with_ready", {63'd0, busy_o}, 64'd1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic        sgn;
    int          c0;
    exp_t        e;

    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    last_res     = 64'd0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result_o, 64'd0);
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_busy", {63'd0, busy_o}, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Unsigned, signed and sign-mixed cases.
    issue(1'b0, 32'd100, 32'd7, 1'b1);
    check("busy_after_start", {63'd0, busy_o}, 64'd1);
    wait_drain("divu_100_7");
    check("divu_100_7_value", last_res, {32'd2, 32'd14});
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_drain("div_m7_2");
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_drain("div_7_m2");

    // Zero divisor and overflow fast paths.
    issue(1'b0, 32'd5, 32'd0, 1'b1);
    wait_drain("divu_5_0");
    issue(1'b1, 32'hFFFF_FFFB, 32'd0, 1'b1);
    wait_drain("div_m5_0");
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_drain("div_ovf");
    check("held_result", result_o, last_res);

    // Annul at iteration 10: no result, idle next cycle, result_o unchanged.
    issue(1'b0, 32'd1000, 32'd3, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    check("annul_busy", {63'd0, busy_o}, 64'd0);
    check("annul_ready", {63'd0, ready_o}, 64'd0);
    check("annul_result_kept", result_o, last_res);
    repeat (40) @(posedge clk);
    #1;
    issue(1'b0, 32'd9, 32'd3, 1'b1);
    wait_drain("divu_9_3");

    // Asynchronous reset at iteration 20 clears outputs at once.
    issue(1'b0, 32'd12345, 32'd67, 1'b0);
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midop_reset_result", result_o, 64'd0);
    check("midop_reset_ready", {63'd0, ready_o}, 64'd0);
    check("midop_reset_busy", {63'd0, busy_o}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    last_res = 64'd0;
    repeat (40) @(posedge clk);
    #1;

    // Back-to-back with start_i held: pulses at c+33 and c+67.
    c0           = cyc;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    e.res = model(1'b0, 32'd1000, 32'd7);
    e.cyc = c0 + 33;
    sb_q.push_back(e);
    e.cyc = c0 + 67;
    sb_q.push_back(e);
    repeat (35) @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_drain("back_to_back");

    // Random operations, biased toward the interesting divisors.
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        3: begin
          a = 32'h8000_0000;
          b = 32'($urandom_range(0, 1)) == 32'd0 ? 32'hFFFF_FFFF : 32'd3;
        end
        4:       b = 32'd0 - 32'($urandom_range(1, 100));
        default: b = $urandom;
      endcase
      issue(sgn, a, b, 1'b1);
      wait_drain("random");
    end

    repeat (5) @(posedge clk);
    #1;
    check("final_idle", {63'd0, busy_o}, 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
